// File: rtl/hamming_serial_rx.sv
// UART-style deserialiser for one Hamming(7,4) codeword per frame (bit 1 first).
// Optional OVERALL_PARITY_EN adds an even-parity bit after codeword bit 7.
module hamming_serial_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:1] codeword_out,
  output logic       codeword_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [BW-1:0]          baud;
  logic [2:0]             bit_cnt;
  logic [7:1]             hold;
`ifdef OVERALL_PARITY_EN
  logic                   par_bit;
`endif

  // Synchroniser idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], rx_in};

  assign rx_s = sync[SYNC_STAGES-1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      baud           <= '0;
      bit_cnt        <= '0;
      hold           <= '0;
      codeword_out   <= '0;
      codeword_valid <= 1'b0;
      frame_err      <= 1'b0;
      parity_err     <= 1'b0;
`ifdef OVERALL_PARITY_EN
      par_bit        <= 1'b0;
`endif
    end else begin
      codeword_valid <= 1'b0;
      frame_err      <= 1'b0;
      parity_err     <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            state <= START;
            baud  <= '0;
          end
        START:
          if (baud == HALF) begin
            if (!rx_s) begin
              state   <= DATA;
              baud    <= '0;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        DATA:
          if (baud == LAST) begin
            baud    <= '0;
            // Shift right: the first bit received ends up at position 1
            hold    <= {rx_s, hold[7:2]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd6)
`ifdef OVERALL_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
          end else begin
            baud <= baud + 1'b1;
          end
        PARITY:
`ifdef OVERALL_PARITY_EN
          if (baud == LAST) begin
            baud    <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
`else
          state <= IDLE;
`endif
        STOP:
          if (baud == LAST) begin
            baud <= '0;
            if (rx_s) begin
              codeword_out   <= hold;
              codeword_valid <= 1'b1;
`ifdef OVERALL_PARITY_EN
              parity_err     <= par_bit ^ (^hold);
`endif
              state          <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        WAIT_IDLE:
          if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Scoreboard bench for hamming_serial_rx: expectations queued at stimulus, popped on output pulses.
module tb_hamming_serial_rx;

  localparam int CPB = 16;
`ifdef OVERALL_PARITY_EN
  localparam int FRAME_BITS = 10;
`else
  localparam int FRAME_BITS = 9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:1] codeword_out;
  logic       codeword_valid, frame_err, parity_err, busy;

  hamming_serial_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in),
    .codeword_out(codeword_out), .codeword_valid(codeword_valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [6:0] cw;
    bit         perr;
  } exp_t;

  exp_t    sb[$];
  longint  vt[$];
  longint  cyc = 0;
  int      n_tests = 0;
  int      n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (codeword_valid || frame_err)) begin
      chk("exclusive", {31'd0, codeword_valid & frame_err}, 0);
      chk("sb_pending", {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
        if (codeword_valid) begin
          vt.push_back(cyc);
          chk("codeword", {25'd0, codeword_out}, {25'd0, e.cw});
          chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:1] cw, input logic stop, input logic par);
    drive_bit(1'b0);
    for (int i = 1; i <= 7; i++) drive_bit(cw[i]);
`ifdef OVERALL_PARITY_EN
    drive_bit(par);
`else
    if (par) begin end
`endif
    drive_bit(stop);
  endtask

  task automatic expect_ok(input logic [7:1] cw, input bit perr);
    exp_t e;
    e.is_err = 1'b0; e.cw = cw; e.perr = perr;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_cw", {25'd0, codeword_out}, 0);
    chk("rst_valid", {31'd0, codeword_valid}, 0);
    chk("rst_ferr", {31'd0, frame_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Clean frame
    expect_ok(7'b1100110, 1'b0);
    send_frame(7'b1100110, 1'b1, ^7'b1100110);
    repeat (10) @(negedge clk);
    chk("busy_after_frame", {31'd0, busy}, 0);

    // Start-bit glitch
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_busy", {31'd0, busy}, 0);
    chk("glitch_cw_hold", {25'd0, codeword_out}, {25'd0, 7'b1100110});

    // Stop bit held low
    e.is_err = 1'b1; e.cw = 7'b0000111; e.perr = 1'b0;
    sb.push_back(e);
    send_frame(7'b0000111, 1'b0, ^7'b0000111);
    repeat (30) @(negedge clk);
    chk("ferr_busy_stuck", {31'd0, busy}, 1);
    chk("ferr_cw_hold", {25'd0, codeword_out}, {25'd0, 7'b1100110});
    rx_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("ferr_busy_release", {31'd0, busy}, 0);

    // Back-to-back frames, zero idle gap
    expect_ok(7'b1110110, 1'b0);
    expect_ok(7'b0000000, 1'b0);
    send_frame(7'b1110110, 1'b1, ^7'b1110110);
    send_frame(7'b0000000, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("b2b_count", vt.size(), 3);
    if (vt.size() >= 2)
      chk("b2b_gap", 32'(vt[vt.size()-1] - vt[vt.size()-2]), FRAME_BITS * CPB);

    // Reset in the middle of data bit 4, checked before the next clock edge
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    rx_in = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cw", {25'd0, codeword_out}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_pulses", {30'd0, codeword_valid, frame_err}, 0);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    expect_ok(7'b1010101, 1'b0);
    send_frame(7'b1010101, 1'b1, ^7'b1010101);
    repeat (10) @(negedge clk);

    // Wrong parity bit: delivered anyway, flagged when the feature is built in
`ifdef OVERALL_PARITY_EN
    expect_ok(7'b0000111, 1'b1);
`else
    expect_ok(7'b0000111, 1'b0);
`endif
    send_frame(7'b0000111, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    chk("final_busy", {31'd0, busy}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
